// File: rtl/memory_stage_pkg.sv
// Shared RV32I memory-stage constants: opcodes, funct3 codes, FSM states
// and the access-alignment rule.
package memory_stage_pkg;

  localparam logic [6:0]  OP_LCC   = 7'b0000011;
  localparam logic [6:0]  OP_SCC   = 7'b0100011;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b10:   return addr_lo != 2'b00;
      2'b01:   return addr_lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_lsu_format.sv
// Combinational load/store lane formatting: byte enables, store replication,
// load lane select with sign/zero extension, and misalignment detect.
module memory_stage_lsu_format
  import memory_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte     = rdata[8*addr_lo +: 8];
    w_half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = is_misaligned(funct3, addr_lo);
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = funct3[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = funct3[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I M stage: pipeline register, data-memory handshake with wait/timeout
// FSM, store formatting and load extension.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC_x,
  input  logic [31:0] inst_x,
  input  logic [31:0] alu_x,
  input  logic [31:0] rs2_x,
  input  logic [31:0] wb_w_bypass,
  input  logic        wm_bypass,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] PC_m,
  output logic [31:0] inst_m,
  output logic [31:0] alu_m,
  output logic [31:0] mem_data_m,
  output logic        stall_m,
  output logic        misalign_m,
  output logic        bus_err_m
);

  logic [31:0] r_pc_m, r_inst_m, r_alu_m, r_rs2_m;
  mem_state_e  r_state;
  logic [CNT_W-1:0] r_cnt;

  logic        w_is_load, w_is_store, w_is_mem;
  logic        w_misaligned, w_req, w_timeout, w_stall;
  logic [31:0] w_store_data, w_load_data, w_wdata;
  logic [3:0]  w_be;

  assign w_is_load    = r_inst_m[6:0] == OP_LCC;
  assign w_is_store   = r_inst_m[6:0] == OP_SCC;
  assign w_is_mem     = w_is_load | w_is_store;
  assign w_store_data = wm_bypass ? wb_w_bypass : r_rs2_m;

  memory_stage_lsu_format u_fmt (
    .funct3     (r_inst_m[14:12]),
    .addr_lo    (r_alu_m[1:0]),
    .store_data (w_store_data),
    .rdata      (dmem_rdata),
    .be         (w_be),
    .wdata      (w_wdata),
    .load_data  (w_load_data),
    .misaligned (w_misaligned)
  );

  assign w_req     = w_is_mem & ~w_misaligned & (r_state == ST_IDLE || r_state == ST_WAIT);
  assign w_timeout = (r_state == ST_WAIT) & ~dmem_ready & (r_cnt == CNT_W'(TIMEOUT_CYCLES));
  // Combinational so F/D/X freeze in the very cycle the memory is not ready.
  assign w_stall   = w_req & ~dmem_ready & ~w_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_m   <= '0;
      r_inst_m <= INST_NOP;
      r_alu_m  <= '0;
      r_rs2_m  <= '0;
    end else if (!w_stall) begin
      r_pc_m   <= PC_x;
      r_inst_m <= inst_x;
      r_alu_m  <= alu_x;
      r_rs2_m  <= rs2_x;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && !dmem_ready) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!w_req || dmem_ready || w_timeout) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign dmem_req   = w_req;
  assign dmem_we    = w_req & w_is_store;
  assign dmem_be    = w_be;
  assign dmem_addr  = {r_alu_m[31:2], 2'b00};
  assign dmem_wdata = w_wdata;
  assign PC_m       = r_pc_m;
  assign inst_m     = r_inst_m;
  assign alu_m      = r_alu_m;
  assign mem_data_m = (w_req & dmem_ready & w_is_load) ? w_load_data : 32'h0;
  assign stall_m    = w_stall;
  assign misalign_m = w_is_mem & w_misaligned;
  assign bus_err_m  = w_timeout;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized and directed bench for memory_stage against a size/offset
// arithmetic reference model of the M stage.
module tb_memory_stage;

  localparam int T = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_x, inst_x, alu_x, rs2_x, wb_w_bypass, dmem_rdata;
  logic        wm_bypass, dmem_ready;
  logic        dmem_req, dmem_we, stall_m, misalign_m, bus_err_m;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, PC_m, inst_m, alu_m, mem_data_m;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc = 0, m_inst = NOP, m_alu = 0, m_rs2 = 0;
  int          m_wait = 0;
  logic        m_stall = 0;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .PC_x(PC_x), .inst_x(inst_x), .alu_x(alu_x),
    .rs2_x(rs2_x), .wb_w_bypass(wb_w_bypass), .wm_bypass(wm_bypass),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .PC_m(PC_m), .inst_m(inst_m), .alu_m(alu_m),
    .mem_data_m(mem_data_m), .stall_m(stall_m), .misalign_m(misalign_m),
    .bus_err_m(bus_err_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'h0, f3, 5'h1, op};
  endfunction

  task automatic model_check();
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        ld, st, mem, aligned, req, tmo;
    int          size, off;
    logic [31:0] data, mask, v, expw, expd;
    op = m_inst[6:0];
    f3 = m_inst[14:12];
    ld = (op == 7'h03);
    st = (op == 7'h23);
    mem = ld | st;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(m_alu % 4);
    aligned = (m_alu % size) == 0;
    req = mem && aligned;
    tmo = req && !dmem_ready && (m_wait == T);
    m_stall = req && !dmem_ready && !tmo;
    check("req", dmem_req, req);
    check("stall", stall_m, m_stall);
    check("misalign", misalign_m, mem && !aligned);
    check("bus_err", bus_err_m, tmo);
    check("pc_m", PC_m, m_pc);
    check("inst_m", inst_m, m_inst);
    check("alu_m", alu_m, m_alu);
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 1;
    if (req) begin
      check("we", dmem_we, st);
      check("addr", dmem_addr, m_alu - off);
      check("be", dmem_be, ((1 << size) - 1) << off);
      if (st) begin
        data = wm_bypass ? wb_w_bypass : m_rs2;
        expw = (size == 1) ? (data & 32'hFF) * 32'h0101_0101 :
               (size == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
        check("wdata", dmem_wdata, expw);
      end
    end
    expd = 0;
    if (req && dmem_ready && ld) begin
      v = (dmem_rdata >> (8 * off)) & mask;
      if (size < 4 && !f3[2] && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
      expd = v;
    end
    check("mem_data", mem_data_m, expd);
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_pc = 0; m_inst = NOP; m_alu = 0; m_rs2 = 0; m_wait = 0;
    end else if (m_stall) begin
      m_wait++;
    end else begin
      m_wait = 0;
      m_pc = PC_x; m_inst = inst_x; m_alu = alu_x; m_rs2 = rs2_x;
    end
  endtask

  task automatic half1();
    @(negedge clk);
    model_check();
  endtask

  task automatic half2();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_x(input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] alu, input logic [31:0] rs2);
    PC_x = pc; inst_x = inst; alu_x = alu; rs2_x = rs2;
  endtask

  // Present one instruction in X for a cycle, then leave a NOP behind it.
  task automatic put(input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] alu, input logic [31:0] rs2);
    drive_x(pc, inst, alu, rs2);
    half1();
    half2();
    drive_x(32'hAAAA_0000, NOP, 32'h5555_5555, 32'h0);
  endtask

  initial begin
    logic [2:0] f3;
    int         k;
    rst_n = 1'b0; wm_bypass = 1'b0; wb_w_bypass = 0; dmem_ready = 1'b1; dmem_rdata = 0;
    drive_x(0, NOP, 0, 0);
    half2();
    half1();
    check("rst_pc", PC_m, 32'h0);
    check("rst_inst", inst_m, NOP);
    check("rst_stall", stall_m, 1'b0);
    half2();
    rst_n = 1'b1;

    put(32'h10, mk(7'h23, 3'b010), 32'h100, 32'hDEAD_BEEF);
    half1();
    check("sw_be", dmem_be, 4'hF);
    check("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
    check("sw_addr", dmem_addr, 32'h100);
    half2();

    put(32'h14, mk(7'h23, 3'b000), 32'h103, 32'h0000_00A5);
    half1();
    check("sb_be", dmem_be, 4'b1000);
    check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    half2();

    dmem_rdata = 32'h0080_0000;
    put(32'h18, mk(7'h03, 3'b000), 32'h102, 32'h0);
    half1();
    check("lb_data", mem_data_m, 32'hFFFF_FF80);
    half2();
    put(32'h1C, mk(7'h03, 3'b100), 32'h102, 32'h0);
    half1();
    check("lbu_data", mem_data_m, 32'h0000_0080);
    half2();

    dmem_ready = 1'b0;
    put(32'h20, mk(7'h03, 3'b010), 32'h200, 32'h0);
    drive_x(32'h99, NOP, 32'h77, 32'h0);
    for (int i = 0; i < 3; i++) begin
      half1();
      check("lw_wait_stall", stall_m, 1'b1);
      check("lw_wait_pc", PC_m, 32'h20);
      half2();
    end
    dmem_ready = 1'b1; dmem_rdata = 32'h1122_3344;
    half1();
    check("lw_wait_data", mem_data_m, 32'h1122_3344);
    check("lw_wait_release", stall_m, 1'b0);
    half2();
    half1();
    check("lw_next_pc", PC_m, 32'h99);
    half2();

    put(32'h24, mk(7'h03, 3'b001), 32'h101, 32'h0);
    half1();
    check("lh_mis_req", dmem_req, 1'b0);
    check("lh_mis_flag", misalign_m, 1'b1);
    check("lh_mis_data", mem_data_m, 32'h0);
    half2();

    dmem_ready = 1'b0;
    put(32'h28, mk(7'h03, 3'b010), 32'h300, 32'h0);
    for (int i = 0; i <= T; i++) begin
      half1();
      check("to_stall", stall_m, (i < T));
      check("to_bus_err", bus_err_m, (i == T));
      half2();
    end
    half1();
    check("to_pulse_end", bus_err_m, 1'b0);
    half2();

    put(32'h2C, mk(7'h23, 3'b010), 32'h400, 32'h1);
    half1();
    half2();
    rst_n = 1'b0;
    half1();
    half2();
    rst_n = 1'b1;
    half1();
    check("rst_wait_req", dmem_req, 1'b0);
    check("rst_wait_err", bus_err_m, 1'b0);
    check("rst_wait_pc", PC_m, 32'h0);
    half2();

    dmem_ready = 1'b1; wm_bypass = 1'b1; wb_w_bypass = 32'h1234_5678;
    put(32'h30, mk(7'h23, 3'b010), 32'h500, 32'hFFFF_FFFF);
    half1();
    check("sw_byp_wdata", dmem_wdata, 32'h1234_5678);
    half2();

    for (int c = 0; c < 600; c++) begin
      k = $urandom_range(0, 2);
      case (k)
        0: begin
          case ($urandom_range(0, 4))
            0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
            default: f3 = 3'b101;
          endcase
          inst_x = mk(7'h03, f3);
        end
        1: begin
          f3 = 3'($urandom_range(0, 2));
          inst_x = mk(7'h23, f3);
        end
        default: inst_x = {$urandom_range(0, 32'h1FF_FFFF), 7'h33};
      endcase
      PC_x = $urandom; alu_x = $urandom; rs2_x = $urandom;
      wb_w_bypass = $urandom; wm_bypass = $urandom_range(0, 1);
      dmem_rdata = $urandom;
      dmem_ready = ((c % 50) < 8) ? 1'b0 : ($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 99) != 0);
      half1();
      half2();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
